reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//  Parametrised register file for the pipelined MIPS datapath; next generation of the 32x32 file.
//  - Two asynchronous read ports and one write port.
//  - Writes occur on the clk rising edge.
//  - After reset, a sweep state machine clears every entry.
//  - Optional write-to-read bypass, so the ID stage sees a same-cycle WB write.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG  1   1: entry 0 reads 0 and ignores writes; 0: entry 0 is an ordinary register
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  reset_n    in   1       one clock; reset is synchronous and active-low
//  reg_write  in   1       write enable
//  wn         in   ADDR_W  write register number
//  wd         in   DATA_W  write data
//  rn1        in   ADDR_W  read port 1 register number
//  rn2        in   ADDR_W  read port 2 register number
//  rd1        out  DATA_W  read port 1 data (combinational)
//  rd2        out  DATA_W  read port 2 data (combinational)
//  busy       out  1       1 while reset or clear sweep is active; file not usable
// BEHAVIOUR
//  State machine: states CLEAR and RUN; clear pointer clr_ptr is ADDR_W bits.
//  - Rising edge with reset_n=0: state<=CLEAR, clr_ptr<=0. No array write happens on that edge.
//  - Each edge in CLEAR with reset_n=1: mem[clr_ptr]<=0 and clr_ptr<=clr_ptr+1.
//  - When clr_ptr==DEPTH-1 on that edge, state<=RUN. clr_ptr wraps to 0.
//  - busy=1 whenever state==CLEAR.
//  - busy falls exactly DEPTH rising edges after the first edge that samples reset_n=1.
//  - Reset asserted mid-sweep restarts the sweep at clr_ptr=0. The full DEPTH-cycle sweep repeats.
//  Reset values: busy=1; rd1=rd2=0; every entry is 0 once busy falls.
//  Write:
//  - In RUN, on an edge with reg_write=1: mem[wn]<=wd.
//  - The write is dropped when ZERO_REG=1 and wn==0.
//  - reg_write is ignored while busy. There is no queuing.
//  Read:
//  - Combinational from the array.
//  - rdX=0 while busy.
//  - rdX=0 when ZERO_REG=1 and rnX==0.
//  - Both ports may address the same entry; both return the same data.
//  Read in the cycle of a write to the same entry: see CONFIGURATION.
//  Simultaneous reset_n=0 and reg_write=1: reset wins; no write.
//  Widths:
//  - wd is stored unmodified. No sign or zero extension.
//  - Addresses cover exactly DEPTH entries. No out-of-range case.
// CONFIGURATION
//  Macro REG_FILE_BYPASS_EN.
//  Defined: bypass is active when all of the following hold:
//  - state==RUN, reg_write=1 and rnX==wn;
//  - the write is not dropped by the ZERO_REG=1/wn==0 rule.
//  While bypass is active, rdX=wd combinationally in the same cycle. Each read port is bypassed independently.
//  Not defined: rdX returns the pre-write array contents. The new value is visible from the next cycle.
// TESTING
//  1 Reset behaviour (defaults):
//    - stimulus: reset_n=0 for 2 edges, then release;
//    - response: busy=1 for exactly 32 edges, then 0;
//    - response: rn1=rn2=k reads rd1=rd2=0 for every k in 0..31.
//  2 Write then read:
//    - stimulus: write wn=5, wd=32'hDEADBEEF; next cycle rn1=5, rn2=5;
//    - response: rd1=rd2=32'hDEADBEEF.
//  3 Register 0:
//    - stimulus: write wn=0, wd=32'h1234; next cycle rn1=0;
//    - response: rd1=0 with ZERO_REG=1; rd1=32'h1234 with ZERO_REG=0.
//  4 Same-cycle read of a written entry:
//    - stimulus: r7=32'h1, then reg_write=1, wn=7, wd=32'hA5A5 with rn1=7 in the same cycle;
//    - response: rd1=32'hA5A5 with REG_FILE_BYPASS_EN; rd1=32'h1 without it;
//    - response: rd1=32'hA5A5 on the next cycle in both builds.
//  5 Reset mid-sweep:
//    - stimulus: assert reset_n=0 when clr_ptr=10, release;
//    - stimulus: attempt write wn=3, wd=32'h55 while busy;
//    - response: busy lasts 32 further edges after release; afterwards r3 reads 0.
//  6 Small configuration (DATA_W=16, ADDR_W=3):
//    - response: sweep lasts 8 edges;
//    - stimulus: write wn=7, wd=16'hFFFF; then write wn=1, wd=16'h0001;
//    - response: r7 reads 16'hFFFF and r1 reads 16'h0001;
//    - response: r0 reads 0 throughout.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised 2R/1W register file with a post-reset clear sweep.
// Define REG_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] rn1,
    input  logic [ADDR_W-1:0] rn2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok;

    assign busy  = (state_q == CLEAR);
    assign wr_ok = (state_q == RUN) && reg_write &&
                   !((ZERO_REG != 0) && (wn == '0));

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + ONE;
                if (clr_ptr_q == LAST) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // The array has no reset of its own; the sweep zeroes it one entry per edge.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (wr_ok) begin
                mem_q[wn] <= wd;
            end
        end
    end

    always_comb begin
        rd1 = mem_q[rn1];
        rd2 = mem_q[rn2];
`ifdef REG_FILE_BYPASS_EN
        if (wr_ok && (rn1 == wn)) rd1 = wd;
        if (wr_ok && (rn2 == wn)) rd2 = wd;
`endif
        if ((ZERO_REG != 0) && (rn1 == '0)) rd1 = '0;
        if ((ZERO_REG != 0) && (rn2 == '0)) rd2 = '0;
        if (busy) begin
            rd1 = '0;
            rd2 = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed, table-driven bench for reg_file_param (default and 16x8 builds).
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  wn = '0, rn1 = '0, rn2 = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd1, rd2;
    logic        busy;

    logic        s_rst = 1'b0;
    logic        s_we = 1'b0;
    logic [2:0]  s_wn = '0, s_rn1 = '0, s_rn2 = '0;
    logic [15:0] s_wd = '0;
    logic [15:0] s_rd1, s_rd2, z_rd1, z_rd2;
    logic        s_busy, z_busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reg_file_param u_dut (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write),
        .wn(wn), .wd(wd), .rn1(rn1), .rn2(rn2),
        .rd1(rd1), .rd2(rd2), .busy(busy)
    );

    reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_small (
        .clk(clk), .reset_n(s_rst), .reg_write(s_we),
        .wn(s_wn), .wd(s_wd), .rn1(s_rn1), .rn2(s_rn2),
        .rd1(s_rd1), .rd2(s_rd2), .busy(s_busy)
    );

    reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_nz (
        .clk(clk), .reset_n(s_rst), .reg_write(s_we),
        .wn(s_wn), .wd(s_wd), .rn1(s_rn1), .rn2(s_rn2),
        .rd1(z_rd1), .rd2(z_rd2), .busy(z_busy)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wn;
        logic [31:0] wd;
        logic [4:0]  rn1;
        logic [4:0]  rn2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input int which, output int n);
        logic b;
        n = 0;
        do begin
            tick();
            n++;
            b = (which == 0) ? busy : s_busy;
        end while (b && n < 200);
    endtask

    initial begin
        int n;
        logic [31:0] exp_byp;

        vecs[0]  = '{1, 5,  32'hDEADBEEF, 1,  2,  32'h0, 32'h0};
        vecs[1]  = '{0, 0,  32'h0,        5,  5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1, 0,  32'h1234,     5,  0,  32'hDEADBEEF, 32'h0};
        vecs[3]  = '{0, 0,  32'h0,        0,  31, 32'h0, 32'h0};
        vecs[4]  = '{1, 31, 32'hFFFFFFFF, 5,  6,  32'hDEADBEEF, 32'h0};
        vecs[5]  = '{1, 6,  32'h80000000, 31, 0,  32'hFFFFFFFF, 32'h0};
        vecs[6]  = '{0, 6,  32'h0,        6,  31, 32'h80000000, 32'hFFFFFFFF};
        vecs[7]  = '{1, 5,  32'h00000001, 31, 1,  32'hFFFFFFFF, 32'h0};
        vecs[8]  = '{0, 0,  32'h0,        5,  6,  32'h1, 32'h80000000};
        vecs[9]  = '{0, 5,  32'h12345678, 5,  5,  32'h1, 32'h1};
        vecs[10] = '{0, 0,  32'h0,        5,  31, 32'h1, 32'hFFFFFFFF};

        // Reset and sweep of the default build.
        tick();
        tick();
        chk("reset_busy", {31'b0, busy}, 32'h1);
        rn1 = 5'd9;
        rn2 = 5'd31;
        #1;
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_rd2", rd2, 32'h0);
        reset_n = 1'b1;
        wait_busy(0, n);
        chk("sweep_len", n, 32);
        for (int k = 0; k < 32; k++) begin
            rn1 = 5'(k);
            rn2 = 5'(k);
            #1;
            chk("clear_rd1", rd1, 32'h0);
            chk("clear_rd2", rd2, 32'h0);
        end

        for (int i = 0; i < 11; i++) begin
            reg_write = vecs[i].we;
            wn  = vecs[i].wn;
            wd  = vecs[i].wd;
            rn1 = vecs[i].rn1;
            rn2 = vecs[i].rn2;
            #1;
            chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
            tick();
        end

        // Same-cycle read of an entry being written.
        reg_write = 1'b1;
        wn = 5'd7;
        wd = 32'h1;
        rn1 = 5'd0;
        tick();
        wd = 32'hA5A5;
        rn1 = 5'd7;
        rn2 = 5'd5;
`ifdef REG_FILE_BYPASS_EN
        exp_byp = 32'hA5A5;
`else
        exp_byp = 32'h1;
`endif
        #1;
        chk("same_cycle_rd1", rd1, exp_byp);
        chk("same_cycle_rd2", rd2, 32'h1);
        tick();
        reg_write = 1'b0;
        #1;
        chk("next_cycle_rd1", rd1, 32'hA5A5);

        // Reset mid-sweep, with a write held the whole time.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_busy", {31'b0, busy}, 32'h1);
        reset_n = 1'b0;
        reg_write = 1'b1;
        wn = 5'd3;
        wd = 32'h55;
        tick();
        reset_n = 1'b1;
        wait_busy(0, n);
        reg_write = 1'b0;
        chk("resweep_len", n, 32);
        rn1 = 5'd3;
        rn2 = 5'd31;
        #1;
        chk("resweep_r3", rd1, 32'h0);
        chk("resweep_r31", rd2, 32'h0);
        rn1 = 5'd7;
        #1;
        chk("resweep_r7", rd1, 32'h0);

        // 16-bit, 8-entry builds.
        tick();
        s_rn1 = 3'd0;
        s_rn2 = 3'd7;
        #1;
        chk("small_reset_busy", {31'b0, s_busy}, 32'h1);
        s_rst = 1'b1;
        wait_busy(1, n);
        chk("small_sweep_len", n, 8);
        chk("nz_sweep_done", {31'b0, z_busy}, 32'h0);
        s_we = 1'b1;
        s_wn = 3'd7;
        s_wd = 16'hFFFF;
        tick();
        s_wn = 3'd1;
        s_wd = 16'h0001;
        tick();
        s_wn = 3'd0;
        s_wd = 16'h1234;
        tick();
        s_we = 1'b0;
        s_rn1 = 3'd7;
        s_rn2 = 3'd1;
        #1;
        chk("small_r7", {16'h0, s_rd1}, 32'hFFFF);
        chk("small_r1", {16'h0, s_rd2}, 32'h0001);
        s_rn1 = 3'd0;
        s_rn2 = 3'd0;
        #1;
        chk("small_r0", {16'h0, s_rd1}, 32'h0);
        chk("nz_r0", {16'h0, z_rd2}, 32'h1234);
        chk("nz_r0_p1", {16'h0, z_rd1}, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
